// File: rtl/uart_tx_fifo.sv
`default_nettype none
// uart_tx_fifo: buffered 8N1/8E1 UART transmitter fed by a first-word-fall-through FIFO (rev 1.0)
module uart_tx_fifo #(
  parameter int N          = 8,
  parameter int PSCALER    = 625,
  parameter int DIV        = 10,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  parity_i,
  input  logic                  wr_en_i,
  input  logic [N-1:0]          wr_data_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  tx_end_o
);

  localparam int BIT_CYCLES = PSCALER * DIV;
  localparam int PW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW         = (N > 1) ? $clog2(N) : 1;
  localparam int DEPTH      = 2 ** DEPTH_LOG2;
  localparam logic [PW-1:0] PS_LAST   = PW'(BIT_CYCLES - 1);
  localparam logic [PW-1:0] PS_PENULT = PW'(BIT_CYCLES - 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic STOP_IS_LAST = (BIT_CYCLES == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [N-1:0]          mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic                  push, pop, bit_done;
  logic [N-1:0]          head;

  state_t         state;
  logic [N-1:0]   shreg;
  logic [BW-1:0]  bit_idx;
  logic [PW-1:0]  presc;
  logic           par_en, par_bit;

  assign level_o  = level;
  assign full_o   = (level == LEVEL_FULL);
  assign empty_o  = (level == '0);
  assign head     = mem[rd_ptr];
  assign bit_done = (presc == PS_LAST);
  // A full FIFO rejects writes even when a pop frees a slot in the same cycle.
  assign push     = wr_en_i && !full_o;
  assign pop      = !empty_o && ((state == IDLE) || (state == STOP && bit_done));

  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      presc    <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      tx_o     <= 1'b1;
      busy_o   <= 1'b0;
      tx_end_o <= 1'b0;
    end else begin
      tx_end_o <= 1'b0;
      presc    <= bit_done ? '0 : presc + 1'b1;
      case (state)
        IDLE: begin
          presc <= '0;
          if (pop) begin
            state   <= START;
            shreg   <= head;
            par_en  <= parity_i;
            par_bit <= ^head;
            tx_o    <= 1'b0;
            busy_o  <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state   <= DATA;
            tx_o    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == BIT_LAST) begin
              if (par_en) begin
                state <= PARITY;
                tx_o  <= par_bit;
              end else begin
                state    <= STOP;
                tx_o     <= 1'b1;
                tx_end_o <= STOP_IS_LAST;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_o    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state    <= STOP;
            tx_o     <= 1'b1;
            tx_end_o <= STOP_IS_LAST;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (pop) begin
              // Next frame starts straight away, no idle gap on the line.
              state   <= START;
              shreg   <= head;
              par_en  <= parity_i;
              par_bit <= ^head;
              tx_o    <= 1'b0;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else if (presc == PS_PENULT) begin
            tx_end_o <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// tb_uart_tx_fifo: directed scenarios for uart_tx_fifo with BIT_CYCLES=4 (rev 1.0)
module tb_uart_tx_fifo;

  logic       sysclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       parity_i = 1'b0;
  logic       wr_en_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic       full_o, empty_o, tx_o, busy_o, tx_end_o;
  logic [4:0] level_o;

  int tests = 0;
  int fails = 0;
  logic exp_tx[$];
  logic exp_end[$];

  uart_tx_fifo #(.N(8), .PSCALER(2), .DIV(2), .DEPTH_LOG2(4)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .parity_i(parity_i), .wr_en_i(wr_en_i),
    .wr_data_i(wr_data_i), .full_o(full_o), .empty_o(empty_o), .level_o(level_o),
    .tx_o(tx_o), .busy_o(busy_o), .tx_end_o(tx_end_o)
  );

  always #5 sysclk = ~sysclk;

  // Expected line: start, LSB-first data, optional even parity, stop; 4 cycles per bit.
  task automatic push_frame(input logic [7:0] d, input logic p);
    logic [10:0] v;
    int len;
    v   = {1'b1, (p ? ^d : 1'b1), d, 1'b0};
    len = p ? 11 : 10;
    for (int b = 0; b < len; b++)
      for (int c = 0; c < 4; c++) begin
        exp_tx.push_back(v[b]);
        exp_end.push_back((b == len - 1) && (c == 3));
      end
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    rst_n = 1'b0; wr_en_i = 1'b0; parity_i = 1'b0;
    exp_tx.delete(); exp_end.delete();
    @(negedge sysclk);
    @(negedge sysclk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge sysclk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({tx_o, busy_o, tx_end_o, empty_o, full_o, level_o} !== {5'b10010, 5'd0}) begin
      fails++;
      $display("FAIL reset_state got tx/busy/end/empty/full/level=%b%b%b%b%b/%0d exp 10010/0",
               tx_o, busy_o, tx_end_o, empty_o, full_o, level_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    wr_en_i = 1'b1; wr_data_i = 8'h55;
    @(negedge sysclk);
    wr_en_i = 1'b0;
    tests++;
    if ({tx_o, busy_o, level_o} !== {2'b10, 5'd1}) begin
      fails++;
      $display("FAIL single_latency got tx/busy/level=%b%b/%0d exp 10/1", tx_o, busy_o, level_o);
    end
    @(negedge sysclk);
    push_frame(8'h55, 1'b0);
    for (int k = 0; k < exp_tx.size(); k++) begin
      tests++;
      if ({tx_o, tx_end_o, busy_o} !== {exp_tx[k], exp_end[k], 1'b1}) begin
        fails++;
        $display("FAIL single_line k=%0d got tx/end/busy=%b%b%b exp %b%b1", k, tx_o, tx_end_o, busy_o, exp_tx[k], exp_end[k]);
      end
      @(negedge sysclk);
    end
    tests++;
    if ({tx_o, busy_o, empty_o, level_o} !== {3'b101, 5'd0}) begin
      fails++;
      $display("FAIL single_after got tx/busy/empty/level=%b%b%b/%0d exp 101/0", tx_o, busy_o, empty_o, level_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    parity_i = 1'b1;
    wr_en_i = 1'b1; wr_data_i = 8'h07;
    @(negedge sysclk);
    wr_data_i = 8'h03;
    @(negedge sysclk);
    wr_en_i = 1'b0;
    push_frame(8'h07, 1'b1);
    push_frame(8'h03, 1'b1);
    for (int k = 0; k < exp_tx.size(); k++) begin
      tests++;
      if ({tx_o, tx_end_o, busy_o} !== {exp_tx[k], exp_end[k], 1'b1}) begin
        fails++;
        $display("FAIL b2b_line k=%0d got tx/end/busy=%b%b%b exp %b%b1", k, tx_o, tx_end_o, busy_o, exp_tx[k], exp_end[k]);
      end
      @(negedge sysclk);
    end
    tests++;
    if ({tx_o, busy_o, level_o} !== {2'b10, 5'd0}) begin
      fails++;
      $display("FAIL b2b_after got tx/busy/level=%b%b/%0d exp 10/0", tx_o, busy_o, level_o);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int f = 0; f <= 16; f++) push_frame(8'(f), 1'b0);
    for (int i = 0; i < 2 + 680; i++) begin
      wr_en_i   = (i < 18);
      wr_data_i = 8'(i);
      if (i == 18) begin
        tests++;
        if ({full_o, empty_o, level_o} !== {2'b10, 5'd16}) begin
          fails++;
          $display("FAIL fill_full got full/empty/level=%b%b/%0d exp 10/16", full_o, empty_o, level_o);
        end
      end
      if (i >= 2) begin
        tests++;
        if ({tx_o, tx_end_o, busy_o} !== {exp_tx[i-2], exp_end[i-2], 1'b1}) begin
          fails++;
          $display("FAIL fill_line k=%0d got tx/end/busy=%b%b%b exp %b%b1", i - 2, tx_o, tx_end_o, busy_o, exp_tx[i-2], exp_end[i-2]);
        end
      end
      @(negedge sysclk);
    end
    wr_en_i = 1'b0;
    tests++;
    if ({tx_o, busy_o, empty_o, level_o} !== {3'b101, 5'd0}) begin
      fails++;
      $display("FAIL fill_after got tx/busy/empty/level=%b%b%b/%0d exp 101/0", tx_o, busy_o, empty_o, level_o);
    end
  endtask

  task automatic test_pop_collision();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      wr_en_i = 1'b1; wr_data_i = 8'(i);
      @(negedge sysclk);
    end
    wr_en_i = 1'b0;
    repeat (41 - 17) @(negedge sysclk);
    tests++;
    if ({tx_end_o, full_o, level_o} !== {2'b11, 5'd16}) begin
      fails++;
      $display("FAIL full_pop_pre got end/full/level=%b%b/%0d exp 11/16", tx_end_o, full_o, level_o);
    end
    wr_en_i = 1'b1; wr_data_i = 8'hAA;
    @(negedge sysclk);
    wr_en_i = 1'b0;
    tests++;
    if ({full_o, level_o} !== {1'b0, 5'd15}) begin
      fails++;
      $display("FAIL full_pop_drop got full/level=%b/%0d exp 0/15", full_o, level_o);
    end

    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr_en_i = 1'b1; wr_data_i = 8'h30 + 8'(i);
      @(negedge sysclk);
    end
    wr_en_i = 1'b0;
    repeat (41 - 6) @(negedge sysclk);
    tests++;
    if ({tx_end_o, level_o} !== {1'b1, 5'd5}) begin
      fails++;
      $display("FAIL mid_pop_pre got end/level=%b/%0d exp 1/5", tx_end_o, level_o);
    end
    wr_en_i = 1'b1; wr_data_i = 8'h99;
    @(negedge sysclk);
    wr_en_i = 1'b0;
    tests++;
    if ({busy_o, tx_o, level_o} !== {2'b10, 5'd5}) begin
      fails++;
      $display("FAIL mid_pop_same got busy/tx/level=%b%b/%0d exp 10/5", busy_o, tx_o, level_o);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en_i = 1'b1; wr_data_i = 8'h00;
      @(negedge sysclk);
    end
    wr_en_i = 1'b0;
    tests++;
    if (level_o !== 5'd3) begin
      fails++;
      $display("FAIL abort_queued got level=%0d exp 3", level_o);
    end
    repeat (8) @(negedge sysclk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({tx_o, busy_o, tx_end_o, empty_o, level_o} !== {4'b1001, 5'd0}) begin
      fails++;
      $display("FAIL abort_now got tx/busy/end/empty/level=%b%b%b%b/%0d exp 1001/0", tx_o, busy_o, tx_end_o, empty_o, level_o);
    end
    @(negedge sysclk);
    @(negedge sysclk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge sysclk);
      tests++;
      if ({tx_o, busy_o, tx_end_o, level_o} !== {3'b100, 5'd0}) begin
        fails++;
        $display("FAIL abort_quiet k=%0d got tx/busy/end/level=%b%b%b/%0d exp 100/0", k, tx_o, busy_o, tx_end_o, level_o);
      end
    end
  endtask

  task automatic test_parity_toggle();
    do_reset();
    parity_i = 1'b1;
    wr_en_i = 1'b1; wr_data_i = 8'h0B;
    @(negedge sysclk);
    wr_data_i = 8'h3C;
    @(negedge sysclk);
    wr_en_i = 1'b0;
    push_frame(8'h0B, 1'b1);
    push_frame(8'h3C, 1'b0);
    for (int k = 0; k < exp_tx.size(); k++) begin
      tests++;
      if ({tx_o, tx_end_o, busy_o} !== {exp_tx[k], exp_end[k], 1'b1}) begin
        fails++;
        $display("FAIL par_toggle_line k=%0d got tx/end/busy=%b%b%b exp %b%b1", k, tx_o, tx_end_o, busy_o, exp_tx[k], exp_end[k]);
      end
      if (k == 10) parity_i = 1'b0;
      @(negedge sysclk);
    end
    tests++;
    if ({tx_o, busy_o} !== 2'b10) begin
      fails++;
      $display("FAIL par_toggle_after got tx/busy=%b%b exp 10", tx_o, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_overflow();
    test_pop_collision();
    test_reset_midframe();
    test_parity_toggle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
